// File: rtl/hex_press_counter_pkg.sv
// Shared types, widths and step arithmetic for the up/down press counter.
package hex_counter_pkg;

    localparam int unsigned COUNT_W  = 8;
    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UP_HELD   = 2'd1,
        DOWN_HELD = 2'd2,
        BOTH_HELD = 2'd3
    } state_t;

    // Returns {wrap, next_count} for a single modulo step in the given direction.
    function automatic logic [COUNT_W:0] step_count(input logic [COUNT_W-1:0] cnt,
                                                     input logic             up);
        logic [COUNT_W:0] r;
        if (up) begin
            r = {cnt == '1, cnt + COUNT_W'(1)};
        end else begin
            r = {cnt == '0, cnt - COUNT_W'(1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_press_counter_if.sv
// Switch inputs and nibble/wrap outputs of the press counter.
interface hex_press_counter_if;

    logic                                 i_Switch_Up;
    logic                                 i_Switch_Down;
    logic [hex_counter_pkg::NIBBLE_W-1:0] o_Upper_Nibble;
    logic [hex_counter_pkg::NIBBLE_W-1:0] o_Lower_Nibble;
    logic                                 o_Wrap;

    // Board/bench side: drives the raw switches, observes the display feed.
    modport master (
        output i_Switch_Up,
        output i_Switch_Down,
        input  o_Upper_Nibble,
        input  o_Lower_Nibble,
        input  o_Wrap
    );

    // Counter side.
    modport slave (
        input  i_Switch_Up,
        input  i_Switch_Down,
        output o_Upper_Nibble,
        output o_Lower_Nibble,
        output o_Wrap
    );

endinterface

// File: rtl/hex_press_counter_switch_debounce.sv
// Two-flop synchroniser followed by a stable-for-N-cycles debouncer.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic switch_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], switch_raw};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= '0;
                level <= sync_q[1];
                press <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_press_counter.sv
// Debounced up/down press counter with auto-repeat, feeding two nibble displays.
module hex_press_counter
    import hex_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    hex_press_counter_if.slave  bus
);

    localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    logic               up_level;
    logic               up_press;
    logic               down_level;
    logic               down_press;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               wrap_q;
    logic               wrap_d;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .switch_raw (bus.i_Switch_Up),
        .level      (up_level),
        .press      (up_press)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .switch_raw (bus.i_Switch_Down),
        .level      (down_level),
        .press      (down_press)
    );

    // State, repeat timer, count and wrap pulse registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state, single count update and timer reload; a second switch always wins over release.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        count_d = count_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_press && down_press) begin
                    state_d = BOTH_HELD;
                    count_d = '0;
                end else if (up_press) begin
                    state_d           = UP_HELD;
                    {wrap_d, count_d} = step_count(count_q, 1'b1);
                    timer_d           = TIMER_W'(REPEAT_DELAY);
                end else if (down_press) begin
                    state_d           = DOWN_HELD;
                    {wrap_d, count_d} = step_count(count_q, 1'b0);
                    timer_d           = TIMER_W'(REPEAT_DELAY);
                end
            end
            UP_HELD: begin
                if (down_level) begin
                    state_d = BOTH_HELD;
                    count_d = '0;
                end else if (!up_level) begin
                    state_d = IDLE;
                end else if (timer_q <= TIMER_W'(1)) begin
                    {wrap_d, count_d} = step_count(count_q, 1'b1);
                    timer_d           = TIMER_W'(REPEAT_RATE);
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            DOWN_HELD: begin
                if (up_level) begin
                    state_d = BOTH_HELD;
                    count_d = '0;
                end else if (!down_level) begin
                    state_d = IDLE;
                end else if (timer_q <= TIMER_W'(1)) begin
                    {wrap_d, count_d} = step_count(count_q, 1'b0);
                    timer_d           = TIMER_W'(REPEAT_RATE);
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            BOTH_HELD: begin
                if (!up_level && !down_level) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_Upper_Nibble = count_q[COUNT_W-1:NIBBLE_W];
    assign bus.o_Lower_Nibble = count_q[NIBBLE_W-1:0];
    assign bus.o_Wrap         = wrap_q;

endmodule

// File: tb/tb_hex_press_counter.sv
// Directed bench for hex_press_counter with short debounce/repeat parameters.
module tb_hex_press_counter;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RR  = 5;

    typedef struct {
        logic       up;
        logic       down;
        int         hold;
        logic [7:0] exp_count;
        int         exp_wraps;
        string      name;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   wrap_seen = 0;
    vec_t vecs[$];

    hex_press_counter_if bus ();

    hex_press_counter #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Count wrap pulses; each lasts one cycle so it is seen once per negedge sample.
    always @(negedge clk) begin
        if (bus.o_Wrap) wrap_seen <= wrap_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] count_now();
        return {bus.o_Upper_Nibble, bus.o_Lower_Nibble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.i_Switch_Up   = 1'b0;
        bus.i_Switch_Down = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic up, input logic down, input int hold,
                           input logic [7:0] exp_count, input int exp_wraps, input string name);
        vec_t v;
        v.up = up; v.down = down; v.hold = hold;
        v.exp_count = exp_count; v.exp_wraps = exp_wraps; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int w0;
        int cp_cyc [9] = '{6, 7, 26, 27, 31, 32, 61, 62, 90};
        int cp_val [9] = '{0, 1, 1,  2,  2,  3,  8,  9,  9};

        bus.i_Switch_Up   = 1'b0;
        bus.i_Switch_Down = 1'b0;

        // Each row starts from the count left by the previous one.
        add_vec(1'b1, 1'b0, 10, 8'h01, 0, "up_tap");
        add_vec(1'b1, 1'b0,  3, 8'h01, 0, "up_glitch_3");
        add_vec(1'b1, 1'b0,  4, 8'h02, 0, "up_min_width_4");
        add_vec(1'b0, 1'b1, 10, 8'h01, 0, "down_tap_a");
        add_vec(1'b0, 1'b1, 10, 8'h00, 0, "down_tap_b");
        add_vec(1'b0, 1'b1, 10, 8'hFF, 1, "down_wrap");
        add_vec(1'b1, 1'b0, 10, 8'h00, 1, "up_wrap");
        add_vec(1'b1, 1'b0, 30, 8'h03, 0, "up_hold_30");
        add_vec(1'b1, 1'b1, 10, 8'h00, 0, "both_clear");
        add_vec(1'b0, 1'b1, 30, 8'hFD, 1, "down_hold_30");

        // Reset state and single-tap latency.
        do_reset();
        check("reset_count", 32'(count_now()), 32'h00);
        check("reset_wrap", 32'(bus.o_Wrap), 32'h0);
        w0 = wrap_seen;
        bus.i_Switch_Up = 1'b1;
        tick(6);
        check("tap_before_latency", 32'(count_now()), 32'h00);
        tick(1);
        check("tap_at_latency", 32'(count_now()), 32'h01);
        tick(3);
        bus.i_Switch_Up = 1'b0;
        tick(20);
        check("tap_no_wrap", 32'(wrap_seen - w0), 32'd0);

        // Table of press patterns.
        do_reset();
        foreach (vecs[i]) begin
            w0 = wrap_seen;
            bus.i_Switch_Up   = vecs[i].up;
            bus.i_Switch_Down = vecs[i].down;
            tick(vecs[i].hold);
            bus.i_Switch_Up   = 1'b0;
            bus.i_Switch_Down = 1'b0;
            tick(20);
            check({vecs[i].name, "_count"}, 32'(count_now()), 32'(vecs[i].exp_count));
            check({vecs[i].name, "_wraps"}, 32'(wrap_seen - w0), 32'(vecs[i].exp_wraps));
        end

        // Long hold: step at 7, repeats at 27, 32, ... until the release is debounced.
        do_reset();
        w0 = wrap_seen;
        bus.i_Switch_Up = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            for (int c = 0; c < 9; c++) begin
                if (cp_cyc[c] == k) check($sformatf("repeat_cycle_%0d", k), 32'(count_now()), 32'(cp_val[c]));
            end
            if (k == 60) bus.i_Switch_Up = 1'b0;
        end
        check("repeat_no_wrap", 32'(wrap_seen - w0), 32'd0);

        // Wrap pulse coincides with the wrapped count and lasts one cycle.
        do_reset();
        bus.i_Switch_Down = 1'b1;
        tick(7);
        check("down_wrap_count", 32'(count_now()), 32'hFF);
        check("down_wrap_pulse", 32'(bus.o_Wrap), 32'h1);
        tick(1);
        check("down_wrap_pulse_end", 32'(bus.o_Wrap), 32'h0);
        tick(2);
        bus.i_Switch_Down = 1'b0;
        tick(20);
        bus.i_Switch_Up = 1'b1;
        tick(7);
        check("up_wrap_count", 32'(count_now()), 32'h00);
        check("up_wrap_pulse", 32'(bus.o_Wrap), 32'h1);
        tick(1);
        check("up_wrap_pulse_end", 32'(bus.o_Wrap), 32'h0);
        tick(2);
        bus.i_Switch_Up = 1'b0;
        tick(20);

        // Both held: clear, then nothing moves until both are released.
        do_reset();
        bus.i_Switch_Up = 1'b1;
        tick(10);
        check("both_pre_count", 32'(count_now()), 32'h01);
        w0 = wrap_seen;
        bus.i_Switch_Down = 1'b1;
        tick(7);
        check("both_clear_count", 32'(count_now()), 32'h00);
        tick(40);
        check("both_held_no_repeat", 32'(count_now()), 32'h00);
        bus.i_Switch_Up = 1'b0;
        tick(30);
        check("one_released_no_step", 32'(count_now()), 32'h00);
        bus.i_Switch_Down = 1'b0;
        tick(20);
        check("both_released_no_step", 32'(count_now()), 32'h00);
        check("both_no_wrap", 32'(wrap_seen - w0), 32'd0);
        bus.i_Switch_Up = 1'b1;
        tick(10);
        bus.i_Switch_Up = 1'b0;
        tick(20);
        check("after_both_tap", 32'(count_now()), 32'h01);

        // Reset in the middle of auto-repeat with the switch still held.
        do_reset();
        bus.i_Switch_Up = 1'b1;
        for (int k = 0; k < 1000 && count_now() != 8'h3A; k++) @(negedge clk);
        check("reach_3A", 32'(count_now()), 32'h3A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_count", 32'(count_now()), 32'h00);
        check("async_reset_wrap", 32'(bus.o_Wrap), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("held_after_reset_early", 32'(count_now()), 32'h00);
        tick(2);
        check("held_after_reset_step", 32'(count_now()), 32'h01);
        tick(10);
        check("held_after_reset_single", 32'(count_now()), 32'h01);
        bus.i_Switch_Up = 1'b0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
